// File: rtl/conv2d_sequencer_pkg.sv
// pkg_parameters: shared geometry defaults and the sequencer state encoding
package pkg_parameters;

    localparam int F_IN_W1              = 12;
    localparam int F_IN_H1              = 9;
    localparam int F_OUT_W1             = 5;
    localparam int F_OUT_H1             = 3;
    localparam int KERNEL_SIZE          = 3;
    localparam int STRIDE               = 2;
    localparam int FEATURE_MAP_ADDRWIDE = 12;

    typedef logic [1:0] conv_seq_state_t;

    localparam conv_seq_state_t S_IDLE  = 2'd0;
    localparam conv_seq_state_t S_RUN   = 2'd1;
    localparam conv_seq_state_t S_DRAIN = 2'd2;
    localparam conv_seq_state_t S_DONE  = 2'd3;

endpackage

// File: rtl/conv2d_sequencer_if.sv
// conv2d_sequencer_if: fmap/weight read request channel
//   rd_valid  - request valid (master -> slave)
//   rd_ready  - request accepted this cycle (slave -> master)
//   fmap_addr - feature-map read address
//   wgt_addr  - kernel weight read address
interface conv2d_sequencer_if
    import pkg_parameters::*;
#(
    parameter int ADDR_W = FEATURE_MAP_ADDRWIDE
);
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] fmap_addr;
    logic [ADDR_W-1:0] wgt_addr;

    modport master (output rd_valid, fmap_addr, wgt_addr, input rd_ready);
    modport slave  (input rd_valid, fmap_addr, wgt_addr, output rd_ready);
endinterface

// File: rtl/conv2d_window_counter.sv
// conv2d_window_counter: kx/ky/ox/oy tap counters with wrap and last flags
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - return all counters to 0
//   adv       - step to the next tap (kx innermost, then ky, ox, oy)
//   kx        - current kernel column
//   *_last    - counter sits at its wrap value
//   tap_first - tap (0,0) of the window
//   tap_last  - tap (K-1,K-1) of the window
//   pass_last - final tap of the final output pixel
module conv2d_window_counter #(
    parameter int K      = 3,
    parameter int OUT_W  = 5,
    parameter int OUT_H  = 3,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    output logic [ADDR_W-1:0] kx,
    output logic              kx_last,
    output logic              ky_last,
    output logic              ox_last,
    output logic              oy_last,
    output logic              tap_first,
    output logic              tap_last,
    output logic              pass_last
);
    logic [ADDR_W-1:0] ky, ox, oy;

    assign kx_last   = kx == ADDR_W'(K - 1);
    assign ky_last   = ky == ADDR_W'(K - 1);
    assign ox_last   = ox == ADDR_W'(OUT_W - 1);
    assign oy_last   = oy == ADDR_W'(OUT_H - 1);
    assign tap_first = kx == '0 && ky == '0;
    assign tap_last  = kx_last && ky_last;
    assign pass_last = tap_last && ox_last && oy_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            kx <= '0;
            ky <= '0;
            ox <= '0;
            oy <= '0;
        end else if (adv) begin
            kx <= kx_last ? '0 : kx + 1'b1;
            if (kx_last) ky <= ky_last ? '0 : ky + 1'b1;
            if (tap_last) ox <= ox_last ? '0 : ox + 1'b1;
            if (tap_last && ox_last) oy <= oy_last ? '0 : oy + 1'b1;
        end
    end
endmodule

// File: rtl/conv2d_sequencer.sv
// conv2d_sequencer: walks every output pixel's KxK window, issuing fmap/weight reads and MAC control
//   clk, rst  - clock, asynchronous active-high reset
//   start     - one-cycle pulse launching a full pass (honoured only when idle)
//   rd        - read request channel (valid/ready, fmap_addr, wgt_addr)
//   mac_clr   - clear accumulator before this cycle's product
//   mac_en    - accumulate the product returned this cycle (one cycle after each fire)
//   pix_done  - accumulator holds a finished pixel; out_addr is its index
//   busy      - pass in progress; done - one-cycle pulse at pass end
module conv2d_sequencer
    import pkg_parameters::*;
#(
    parameter int IN_W   = F_IN_W1,
    parameter int IN_H   = F_IN_H1,
    parameter int OUT_W  = F_OUT_W1,
    parameter int OUT_H  = F_OUT_H1,
    parameter int K      = KERNEL_SIZE,
    parameter int STRIDE = pkg_parameters::STRIDE,
    parameter int ADDR_W = FEATURE_MAP_ADDRWIDE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    conv2d_sequencer_if.master  rd,
    output logic                mac_clr,
    output logic                mac_en,
    output logic                pix_done,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                busy,
    output logic                done
);
    if ((OUT_H - 1) * STRIDE + K > IN_H || (OUT_W - 1) * STRIDE + K > IN_W) begin : g_geom_err
        $error("conv2d_sequencer: output window exceeds the input map");
    end

    conv_seq_state_t   state;
    logic              fire, launch;
    logic [ADDR_W-1:0] kx;
    logic              kx_last, ky_last, ox_last, oy_last, tap_first, tap_last, pass_last;
    // Running address offsets replace the multiplies: oy*STRIDE*IN_W, ky*IN_W, ox*STRIDE, ky*K
    logic [ADDR_W-1:0] oy_off, ky_off, col_off, wk, pix_idx;

    assign fire         = rd.rd_valid && rd.rd_ready;
    assign launch       = state == S_IDLE && start;
    assign rd.rd_valid  = state == S_RUN;
    assign rd.fmap_addr = oy_off + ky_off + col_off + kx;
    assign rd.wgt_addr  = wk + kx;
    assign busy         = state != S_IDLE;
    assign done         = state == S_DONE;

    conv2d_window_counter #(.K(K), .OUT_W(OUT_W), .OUT_H(OUT_H), .ADDR_W(ADDR_W)) u_cnt (
        .clk(clk), .rst(rst), .clr(launch), .adv(fire), .kx(kx),
        .kx_last(kx_last), .ky_last(ky_last), .ox_last(ox_last), .oy_last(oy_last),
        .tap_first(tap_first), .tap_last(tap_last), .pass_last(pass_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state == S_IDLE  ? (start ? S_RUN : S_IDLE) :
                          state == S_RUN   ? (fire && pass_last ? S_DRAIN : S_RUN) :
                          state == S_DRAIN ? S_DONE : S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oy_off   <= '0;
            ky_off   <= '0;
            col_off  <= '0;
            wk       <= '0;
            pix_idx  <= '0;
            out_addr <= '0;
            mac_en   <= 1'b0;
            mac_clr  <= 1'b0;
            pix_done <= 1'b0;
        end else begin
            // Memory returns data one cycle after the fire, so MAC control is the fire delayed by one
            mac_en   <= fire;
            mac_clr  <= fire && tap_first;
            pix_done <= fire && tap_last;
            if (launch) begin
                oy_off  <= '0;
                ky_off  <= '0;
                col_off <= '0;
                wk      <= '0;
                pix_idx <= '0;
            end else if (fire) begin
                if (kx_last) begin
                    ky_off <= ky_last ? '0 : ky_off + ADDR_W'(IN_W);
                    wk     <= ky_last ? '0 : wk + ADDR_W'(K);
                end
                if (tap_last) begin
                    col_off  <= ox_last ? '0 : col_off + ADDR_W'(STRIDE);
                    pix_idx  <= pass_last ? '0 : pix_idx + 1'b1;
                    out_addr <= pix_idx;
                end
                if (tap_last && ox_last) oy_off <= oy_last ? '0 : oy_off + ADDR_W'(STRIDE * IN_W);
            end
        end
    end
endmodule
